// File: rtl/key_debounce_pkg.sv
// Shared state encoding and elaboration-time helpers for the multi-channel key debouncer.
// Constants and functions only: no logic, no latency, no backpressure.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DB_DN = 2'd1,
        DOWN  = 2'd2,
        DB_UP = 2'd3
    } state_t;

    function automatic int CLOG2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

    function automatic int MAX2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop sync, edge detect, debounce/long-press FSM, registered pulses.
// Pulses appear one cycle after the deciding tick; free-running inputs, no backpressure.
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int CW          = CLOG2(MAX2(DEBOUNCE_MS, LONG_MS) + 1)
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic key_n_i,
    input  logic tick_i,
    output logic state_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam logic [CW-1:0] DB_TGT   = CW'(DEBOUNCE_MS);
    localparam logic [CW-1:0] LONG_TGT = CW'(LONG_MS);

    logic          sync1_q, sync2_q, prev_q;
    state_t        state_q, state_d;
    logic [CW-1:0] db_cnt_q, db_cnt_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          long_q, long_d;

    logic          fall, rise, any_edge;
    logic [CW-1:0] db_inc, hold_inc;

    // Key is active-low: a fall on the synchronised pin is a press attempt.
    assign fall     = prev_q & ~sync2_q;
    assign rise     = ~prev_q & sync2_q;
    assign any_edge = fall | rise;
    assign db_inc   = (db_cnt_q >= DB_TGT) ? DB_TGT : db_cnt_q + CW'(1);
    assign hold_inc = hold_cnt_q + CW'(1);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            state_q    <= UP;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            press_q    <= 1'b0;
            rel_q      <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            sync1_q    <= key_n_i;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            state_q    <= state_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            press_q    <= press_d;
            rel_q      <= rel_d;
            long_q     <= long_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        db_cnt_d   = db_cnt_q;
        hold_cnt_d = hold_cnt_q;
        press_d    = 1'b0;
        rel_d      = 1'b0;
        long_d     = 1'b0;
        case (state_q)
            UP: begin
                hold_cnt_d = '0;
                if (fall) begin
                    state_d  = DB_DN;
                    db_cnt_d = '0;
                end
            end
            DB_DN: begin
                if (any_edge) begin
                    db_cnt_d = '0;
                end else if (tick_i) begin
                    db_cnt_d = db_inc;
                    if (db_inc == DB_TGT) begin
                        if (!sync2_q) begin
                            state_d    = DOWN;
                            press_d    = 1'b1;
                            hold_cnt_d = '0;
                        end else begin
                            state_d = UP;
                        end
                    end
                end
            end
            DOWN: begin
                if (rise) begin
                    state_d  = DB_UP;
                    db_cnt_d = '0;
                end else if (tick_i && (LONG_MS != 0) && (hold_cnt_q != LONG_TGT)) begin
                    // Saturating at the target makes the long pulse once-per-press.
                    hold_cnt_d = hold_inc;
                    long_d     = (hold_inc == LONG_TGT);
                end
            end
            DB_UP: begin
                if (any_edge) begin
                    db_cnt_d = '0;
                end else if (tick_i) begin
                    db_cnt_d = db_inc;
                    if (db_inc == DB_TGT) begin
                        if (sync2_q) begin
                            state_d = UP;
                            rel_d   = 1'b1;
                        end else begin
                            state_d = DOWN;
                        end
                    end
                end
            end
            default: state_d = UP;
        endcase
    end

    assign state_o   = (state_q == DOWN) || (state_q == DB_UP);
    assign press_o   = press_q;
    assign release_o = rel_q;
    assign long_o    = long_q;

endmodule

// File: rtl/key_debounce_multi.sv
// CH-channel key conditioner sharing one 1 ms prescaler across per-channel debouncers.
// Press/release ~DEBOUNCE_MS ms after the last sync edge; no backpressure, pulses are 1 CLK.
module key_debounce_multi
    import key_debounce_pkg::*;
#(
    parameter int CH          = 4,
    parameter int CLK_HZ      = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000
) (
    input  logic          CLK,
    input  logic          RST_n,
    input  logic [CH-1:0] Key_In,
    output logic [CH-1:0] Key_State,
    output logic [CH-1:0] Press_Pulse,
    output logic [CH-1:0] Release_Pulse,
    output logic [CH-1:0] Long_Pulse
);

    localparam int T1MS = CLK_HZ / 1000;
    localparam int PW   = (T1MS > 1) ? CLOG2(T1MS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(T1MS - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          tick;

    assign tick    = (presc_q == PRESC_LAST);
    assign presc_d = tick ? '0 : presc_q + PW'(1);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_MS (DEBOUNCE_MS),
            .LONG_MS     (LONG_MS)
        ) u_ch (
            .CLK       (CLK),
            .RST_n     (RST_n),
            .key_n_i   (Key_In[g]),
            .tick_i    (tick),
            .state_o   (Key_State[g]),
            .press_o   (Press_Pulse[g]),
            .release_o (Release_Pulse[g]),
            .long_o    (Long_Pulse[g])
        );
    end

endmodule

// File: doc/key_debounce_multi.md
# key_debounce_multi

Parametrised multi-channel push-button conditioner for active-low keys. It synchronises up to CH raw key inputs and debounces both edges, with a re-check of the key level after the debounce window. Per channel it emits one-cycle press, release and long-press pulses plus a clean level. It sits between board key pins and the application FSMs, and replaces per-key single-channel debounce instances with one shared 1 ms timebase.

## Interface
- CH, 4: number of key channels (1..16).
- CLK_HZ, 50_000_000: CLK frequency; tick period T1MS = CLK_HZ/1000 cycles.
- DEBOUNCE_MS, 20: debounce window in ms ticks (1..255).
- LONG_MS, 1000: hold time for long-press pulse in ms ticks; 0 disables long-press.

Ports:
- CLK  in  1  system clock.
- RST_n  in  1  reset, asynchronous, active-low.
- Key_In  in  CH  raw key pins, low = pressed, asynchronous to CLK.
- Key_State  out  CH  debounced level, 1 = pressed.
- Press_Pulse  out  CH  one-cycle pulse on a confirmed press.
- Release_Pulse  out  CH  one-cycle pulse on a confirmed release.
- Long_Pulse  out  CH  one-cycle pulse once per press after LONG_MS held.

## Operation
- Two-flop synchroniser per channel; sync flops reset to 1 (released). Edge detect compares sync output with its previous value.
- Shared prescaler counts 0..T1MS-1 free-running and asserts tick for one cycle at T1MS-1. Width is $clog2(T1MS).
- Per-channel FSM has four states:
  - UP: on falling edge -> DB_DN, ms count cleared.
  - DB_DN: any edge clears ms count. Each tick increments it. When count reaches DEBOUNCE_MS, sample sync level: low -> DOWN with Press_Pulse; high -> UP with no pulse (glitch rejected).
  - DOWN: on rising edge -> DB_UP, ms count cleared. Otherwise ticks increment a hold counter. When the hold counter reaches LONG_MS (LONG_MS≠0), Long_Pulse fires once; the counter saturates and cannot fire again until the next press.
  - DB_UP: mirror of DB_DN. Confirmed high -> UP with Release_Pulse; still low -> DOWN with no pulse and the hold counter kept.
- Key_State is 1 in DOWN and DB_UP, 0 in UP and DB_DN.
- Channels are fully independent. Simultaneous events on several channels produce pulses in the same cycle.
- Counter width is $clog2(max(DEBOUNCE_MS, LONG_MS)+1); counters saturate and never wrap.

## Timing
- Reset values: all outputs 0, all FSMs UP, prescaler 0, all counters 0. RST_n assertion mid-debounce aborts immediately with no pulse. After release, a key already held low passes through DB_DN and gives one Press_Pulse.
- Pulses are registered, exactly 1 CLK wide, asserted the cycle after the tick at which the count reaches its target.
- Debounce window from the last input edge, measured at the sync output: more than (DEBOUNCE_MS-1)·T1MS and at most DEBOUNCE_MS·T1MS+1 cycles (tick phase jitter).
- Pin-to-sync latency is 2 cycles; edge detect adds 1.
- Press_Pulse and Long_Pulse never coincide on one channel. Long_Pulse is at least one tick later.

## Structure
- Shared package key_debounce_pkg holds the state encoding localparams (UP, DB_DN, DOWN, DB_UP) and a CLOG2 helper function.
- Sub-module key_debounce_ch holds the synchroniser, edge detect, FSM and counters for one channel. It takes tick as an input and is instantiated CH times in a generate loop. The prescaler lives in the top.

## Test plan
Bench parameters: CLK_HZ=10_000 (T1MS=10), DEBOUNCE_MS=3, LONG_MS=8, CH=4.
- Clean press on ch0 held 50 cycles, then released -> Press_Pulse[0] once 21..32 cycles after the edge. Key_State[0]=1 until release is confirmed, then Release_Pulse[0] once.
- Bounce on ch1: 5 toggles spaced 4 cycles, then steady low -> exactly one Press_Pulse[1], at least 21 cycles after the last toggle.
- Glitch on ch2: low for 15 cycles, then high -> no pulses, Key_State[2] stays 0.
- Hold ch3 for 120 cycles -> Press_Pulse[3], then one Long_Pulse[3] about 80 cycles later, with no second Long_Pulse.
- Press ch0 and ch1 in the same cycle -> Press_Pulse[0] and Press_Pulse[1] in the same cycle.
- Assert RST_n=0 during DB_DN on ch0 with the key held; release reset -> all outputs 0 during reset, then one Press_Pulse[0] within 2 debounce windows.
